// File: rtl/packet_loader.sv
// Ingress packet loader: packs a byte stream big-endian into 32-bit SRAM words
// at BASE_ADDR, then hands the packet to the executor and waits for exec_done_i.
`ifndef ADDR_BUS
`define ADDR_BUS 15:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif

module packet_loader #(
  parameter int unsigned BASE_ADDR  = 64,
  parameter int unsigned MAX_WORDS  = 512,
  parameter bit          CLEAR_CSUM = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid_i,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_last_i,
  output logic             rx_ready_o,
  output logic             sram_ce_o,
  output logic             sram_we_o,
  output logic [`ADDR_BUS] sram_addr_o,
  output logic [3:0]       sram_sel_o,
  output logic [`DATA_BUS] sram_data_o,
  output logic             start_o,
  output logic [`ADDR_BUS] start_addr_o,
  input  logic             exec_done_i,
  output logic [15:0]      pkt_len_o,
  output logic             trunc_err_o
);

  localparam logic [`ADDR_BUS] BASE_C    = BASE_ADDR[`ADDR_BUS];
  localparam logic [`ADDR_BUS] MAX_C     = MAX_WORDS[`ADDR_BUS];
  localparam logic [`ADDR_BUS] ONE_A     = 1;
  localparam logic [15:0]      PKT_MAX_C = 16'(MAX_WORDS * 4);

  typedef enum logic [1:0] {RECV, FLUSH, EXEC, DRAIN} state_t;

  state_t             state, state_nx;
  logic [15:0]        byte_cnt, byte_cnt_nx;
  logic [`ADDR_BUS]   word_idx, word_idx_nx;
  logic [31:0]        word_buf, word_buf_nx;
  logic [31:0]        packed_word;
  logic [3:0]         lane_sel;
  logic [7:0]         byte_val;
  logic [1:0]         lane;
  logic               accept;
  logic               ready_nx, wr_nx, start_nx, trunc_nx;
  logic [`ADDR_BUS]   addr_nx;
  logic [3:0]         sel_nx;
  logic [`DATA_BUS]   data_nx;
  logic [15:0]        pkt_len_nx;

  assign start_addr_o = BASE_C;
  assign accept       = rx_valid_i & rx_ready_o;
  assign lane         = byte_cnt[1:0];

  // Merge the incoming byte into the word being built; lane 0 starts a fresh word.
  always_comb begin
    byte_val = rx_data_i;
    if (CLEAR_CSUM && (byte_cnt == 16'd24 || byte_cnt == 16'd25))
      byte_val = 8'h00;
    packed_word = '0;
    lane_sel    = 4'b0000;
    case (lane)
      2'd0: begin packed_word = {byte_val, 24'h000000};                   lane_sel = 4'b1000; end
      2'd1: begin packed_word = {word_buf[31:24], byte_val, 16'h0000};    lane_sel = 4'b1100; end
      2'd2: begin packed_word = {word_buf[31:16], byte_val, 8'h00};       lane_sel = 4'b1110; end
      default: begin packed_word = {word_buf[31:8], byte_val};            lane_sel = 4'b1111; end
    endcase
  end

  always_comb begin
    state_nx    = state;
    byte_cnt_nx = byte_cnt;
    word_idx_nx = word_idx;
    word_buf_nx = word_buf;
    wr_nx       = 1'b0;
    addr_nx     = sram_addr_o;
    sel_nx      = sram_sel_o;
    data_nx     = sram_data_o;
    pkt_len_nx  = pkt_len_o;
    trunc_nx    = trunc_err_o;
    case (state)
      RECV: begin
        if (accept) begin
          if (word_idx == MAX_C) begin
            // Out of room: nothing more is written for this packet.
            if (rx_last_i) begin
              trunc_nx    = 1'b1;
              pkt_len_nx  = PKT_MAX_C;
              byte_cnt_nx = '0;
              word_idx_nx = '0;
            end else begin
              state_nx = DRAIN;
            end
          end else begin
            word_buf_nx = packed_word;
            byte_cnt_nx = byte_cnt + 16'd1;
            if (lane == 2'd3 || rx_last_i) begin
              wr_nx       = 1'b1;
              addr_nx     = BASE_C + word_idx;
              sel_nx      = lane_sel;
              data_nx     = packed_word;
              word_idx_nx = word_idx + ONE_A;
            end
            if (rx_last_i) begin
              state_nx    = FLUSH;
              pkt_len_nx  = byte_cnt + 16'd1;
              trunc_nx    = 1'b0;
              byte_cnt_nx = '0;
              word_idx_nx = '0;
            end
          end
        end
      end
      FLUSH: state_nx = EXEC;
      EXEC: begin
        if (exec_done_i)
          state_nx = RECV;
      end
      DRAIN: begin
        if (accept && rx_last_i) begin
          state_nx    = RECV;
          trunc_nx    = 1'b1;
          pkt_len_nx  = PKT_MAX_C;
          byte_cnt_nx = '0;
          word_idx_nx = '0;
        end
      end
      default: state_nx = RECV;
    endcase
    ready_nx = (state_nx == RECV) || (state_nx == DRAIN);
    start_nx = (state_nx == EXEC);
  end

  // Handshake outputs are registered from the next state so reset can hold them low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RECV;
      byte_cnt    <= '0;
      word_idx    <= '0;
      word_buf    <= '0;
      rx_ready_o  <= 1'b0;
      sram_ce_o   <= 1'b0;
      sram_we_o   <= 1'b0;
      sram_addr_o <= '0;
      sram_sel_o  <= '0;
      sram_data_o <= '0;
      start_o     <= 1'b0;
      pkt_len_o   <= '0;
      trunc_err_o <= 1'b0;
    end else begin
      state       <= state_nx;
      byte_cnt    <= byte_cnt_nx;
      word_idx    <= word_idx_nx;
      word_buf    <= word_buf_nx;
      rx_ready_o  <= ready_nx;
      sram_ce_o   <= wr_nx;
      sram_we_o   <= wr_nx;
      sram_addr_o <= addr_nx;
      sram_sel_o  <= sel_nx;
      sram_data_o <= data_nx;
      start_o     <= start_nx;
      pkt_len_o   <= pkt_len_nx;
      trunc_err_o <= trunc_nx;
    end
  end

endmodule

// File: tb/tb_packet_loader.sv
// Bench for packet_loader: three parameterisations, directed and random packets,
// every SRAM write compared against a byte-image reference model.
module tb_packet_loader;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid [3];
  logic [7:0]  rx_data  [3];
  logic        rx_last  [3];
  logic        rx_ready [3];
  logic        ce       [3];
  logic        we       [3];
  logic [15:0] addr     [3];
  logic [3:0]  sel      [3];
  logic [31:0] data     [3];
  logic        start    [3];
  logic [15:0] saddr    [3];
  logic        exec_done[3];
  logic [15:0] plen     [3];
  logic        trunc    [3];

  int unsigned maxw [3] = '{512, 512, 4};
  bit          clr  [3] = '{1'b1, 1'b0, 1'b1};

  int ntests = 0;
  int nfail  = 0;

  wr_t wq [3][$];

  always #5 clk = ~clk;

  packet_loader #(.BASE_ADDR(64), .MAX_WORDS(512), .CLEAR_CSUM(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .rx_valid_i(rx_valid[0]), .rx_data_i(rx_data[0]), .rx_last_i(rx_last[0]),
    .rx_ready_o(rx_ready[0]), .sram_ce_o(ce[0]), .sram_we_o(we[0]), .sram_addr_o(addr[0]),
    .sram_sel_o(sel[0]), .sram_data_o(data[0]), .start_o(start[0]), .start_addr_o(saddr[0]),
    .exec_done_i(exec_done[0]), .pkt_len_o(plen[0]), .trunc_err_o(trunc[0]));

  packet_loader #(.BASE_ADDR(64), .MAX_WORDS(512), .CLEAR_CSUM(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .rx_valid_i(rx_valid[1]), .rx_data_i(rx_data[1]), .rx_last_i(rx_last[1]),
    .rx_ready_o(rx_ready[1]), .sram_ce_o(ce[1]), .sram_we_o(we[1]), .sram_addr_o(addr[1]),
    .sram_sel_o(sel[1]), .sram_data_o(data[1]), .start_o(start[1]), .start_addr_o(saddr[1]),
    .exec_done_i(exec_done[1]), .pkt_len_o(plen[1]), .trunc_err_o(trunc[1]));

  packet_loader #(.BASE_ADDR(64), .MAX_WORDS(4), .CLEAR_CSUM(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .rx_valid_i(rx_valid[2]), .rx_data_i(rx_data[2]), .rx_last_i(rx_last[2]),
    .rx_ready_o(rx_ready[2]), .sram_ce_o(ce[2]), .sram_we_o(we[2]), .sram_addr_o(addr[2]),
    .sram_sel_o(sel[2]), .sram_data_o(data[2]), .start_o(start[2]), .start_addr_o(saddr[2]),
    .exec_done_i(exec_done[2]), .pkt_len_o(plen[2]), .trunc_err_o(trunc[2]));

  // Capture every SRAM write cycle shortly after the clock edge.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    always begin
      @(posedge clk);
      #1;
      if (ce[g]) wq[g].push_back({we[g], addr[g], sel[g], data[g]});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic string tg(input string s, input int d);
    return $sformatf("%s_d%0d", s, d);
  endfunction

  function automatic bq_t ramp(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'(i));
    return q;
  endfunction

  function automatic bq_t rnd_pkt(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  // Reference: the stored image is the packet prefix that fits, with the checksum
  // bytes blanked; one write per 4-byte group, lanes enabled for bytes present.
  task automatic build_expect(input int d, input bq_t pkt, output wr_t exp[$],
                              output logic [15:0] elen, output bit etr);
    int unsigned cap, n, lm;
    logic [7:0]  b;
    wr_t         w;
    cap  = maxw[d] * 4;
    n    = (pkt.size() > cap) ? cap : pkt.size();
    etr  = (pkt.size() > cap);
    elen = 16'(n);
    exp.delete();
    for (int unsigned i = 0; i < n; i++) begin
      b  = (clr[d] && (i == 24 || i == 25)) ? 8'h00 : pkt[i];
      lm = i % 4;
      if (lm == 0) begin
        w.we = 1'b1; w.addr = 16'(64 + i / 4); w.sel = '0; w.data = '0;
      end else begin
        w = exp[exp.size() - 1];
        exp.delete(exp.size() - 1);
      end
      w.sel[3 - lm] = 1'b1;
      w.data[8 * (3 - lm) +: 8] = b;
      exp.push_back(w);
    end
  endtask

  task automatic send_pkt(input int d, input bq_t pkt, input bit gaps);
    int unsigned i, budget;
    i = 0;
    budget = 0;
    while (i < pkt.size()) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        rx_valid[d] = 1'b0;
        rx_last[d]  = 1'b0;
      end else begin
        rx_valid[d] = 1'b1;
        rx_data[d]  = pkt[i];
        rx_last[d]  = (i == pkt.size() - 1);
        if (rx_ready[d]) i++;
      end
      budget++;
      if (budget > 2000) begin
        chk(tg("send_timeout", d), 64'(i), 64'(pkt.size()));
        break;
      end
    end
    @(negedge clk);
    rx_valid[d] = 1'b0;
    rx_last[d]  = 1'b0;
  endtask

  task automatic finish_exec(input int d);
    @(negedge clk);
    exec_done[d] = 1'b1;
    @(negedge clk);
    exec_done[d] = 1'b0;
    chk(tg("start_after_done", d), start[d], 1'b0);
    chk(tg("ready_after_done", d), rx_ready[d], 1'b1);
  endtask

  // Called at the first falling edge after the last byte was accepted.
  task automatic check_pkt(input int d, input bq_t pkt, input int base, input bit do_exec);
    wr_t         exp[$];
    logic [15:0] elen;
    bit          etr;
    build_expect(d, pkt, exp, elen, etr);
    if (!etr) begin
      chk(tg("start_flush", d), start[d], 1'b0);
      @(negedge clk);
      chk(tg("start_rise", d), start[d], 1'b1);
      chk(tg("ready_exec", d), rx_ready[d], 1'b0);
    end else begin
      repeat (3) @(negedge clk);
      chk(tg("start_trunc", d), start[d], 1'b0);
      chk(tg("ready_trunc", d), rx_ready[d], 1'b1);
    end
    chk(tg("pkt_len", d), plen[d], elen);
    chk(tg("trunc_err", d), trunc[d], etr);
    chk(tg("wr_count", d), 64'(wq[d].size() - base), 64'(exp.size()));
    for (int k = 0; k < exp.size(); k++)
      if (base + k < wq[d].size())
        chk($sformatf("write%0d_d%0d", k, d), wq[d][base + k], exp[k]);
    if (!etr && do_exec) finish_exec(d);
  endtask

  task automatic check_reset(input int d);
    chk(tg("rst_ce", d), ce[d], 1'b0);
    chk(tg("rst_we", d), we[d], 1'b0);
    chk(tg("rst_addr", d), addr[d], 16'h0);
    chk(tg("rst_sel", d), sel[d], 4'h0);
    chk(tg("rst_data", d), data[d], 32'h0);
    chk(tg("rst_start", d), start[d], 1'b0);
    chk(tg("rst_ready", d), rx_ready[d], 1'b0);
    chk(tg("rst_pkt_len", d), plen[d], 16'h0);
    chk(tg("rst_trunc", d), trunc[d], 1'b0);
    chk(tg("rst_start_addr", d), saddr[d], 16'd64);
  endtask

  initial begin
    bq_t p, p2;
    int  base, d, n;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_valid[i] = 1'b0; rx_data[i] = '0; rx_last[i] = 1'b0; exec_done[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) check_reset(i);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk(tg("ready_out_of_reset", i), rx_ready[i], 1'b1);

    // 40-byte ramp with checksum clear
    p = ramp(40);
    base = wq[0].size();
    send_pkt(0, p, 1'b0);
    check_pkt(0, p, base, 1'b0);
    if (wq[0].size() > base + 6) begin
      chk("word64_d0", wq[0][base].data, 32'h00010203);
      chk("word70_d0", wq[0][base + 6].data, 32'h00001A1B);
    end

    // Second packet offered while the executor runs: no handshake, no SRAM traffic
    p2 = rnd_pkt(13);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx_valid[0] = 1'b1; rx_data[0] = p2[0]; rx_last[0] = 1'b0;
      chk("bp_ready_d0", rx_ready[0], 1'b0);
      chk("bp_ce_d0", ce[0], 1'b0);
      chk("bp_start_d0", start[0], 1'b1);
    end
    @(negedge clk);
    rx_valid[0] = 1'b0;
    exec_done[0] = 1'b1;
    @(negedge clk);
    exec_done[0] = 1'b0;
    chk("bp_start_drop_d0", start[0], 1'b0);
    chk("bp_ready_rise_d0", rx_ready[0], 1'b1);
    base = wq[0].size();
    send_pkt(0, p2, 1'b1);
    check_pkt(0, p2, base, 1'b1);

    // exec_done outside EXEC has no effect
    @(negedge clk);
    exec_done[0] = 1'b1;
    @(negedge clk);
    exec_done[0] = 1'b0;
    chk("idle_done_start_d0", start[0], 1'b0);
    chk("idle_done_ready_d0", rx_ready[0], 1'b1);

    // 42-byte ramp, no checksum clear, partial last word
    p = ramp(42);
    base = wq[1].size();
    send_pkt(1, p, 1'b0);
    check_pkt(1, p, base, 1'b0);
    if (wq[1].size() > base + 10) begin
      chk("word70_d1", wq[1][base + 6].data, 32'h18191A1B);
      chk("last_addr_d1", wq[1][base + 10].addr, 16'd74);
      chk("last_sel_d1", wq[1][base + 10].sel, 4'b1100);
      chk("last_data_d1", wq[1][base + 10].data, 32'h28290000);
    end
    finish_exec(1);

    // Truncation with MAX_WORDS=4, then recovery and an exactly-full packet
    p = ramp(20);
    base = wq[2].size();
    send_pkt(2, p, 1'b0);
    check_pkt(2, p, base, 1'b1);
    chk("trunc_len_d2", plen[2], 16'd16);
    p = rnd_pkt(8);
    base = wq[2].size();
    send_pkt(2, p, 1'b1);
    check_pkt(2, p, base, 1'b1);
    p = rnd_pkt(16);
    base = wq[2].size();
    send_pkt(2, p, 1'b0);
    check_pkt(2, p, base, 1'b1);

    // One-byte packet
    p = {8'hAB};
    base = wq[0].size();
    send_pkt(0, p, 1'b0);
    check_pkt(0, p, base, 1'b1);

    // Reset in the middle of a packet
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rx_valid[0] = 1'b1; rx_data[0] = 8'(8'hC0 + i); rx_last[0] = 1'b0;
    end
    @(negedge clk);
    rx_valid[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset(0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_start_d0", start[0], 1'b0);
    p = rnd_pkt(8);
    base = wq[0].size();
    send_pkt(0, p, 1'b0);
    check_pkt(0, p, base, 1'b1);

    // Randomised packets across all three configurations
    for (int k = 0; k < 14; k++) begin
      d = $urandom_range(0, 2);
      n = (d == 2) ? $urandom_range(1, 24) : $urandom_range(1, 60);
      p = rnd_pkt(n);
      base = wq[d].size();
      send_pkt(d, p, 1'($urandom_range(0, 1)));
      check_pkt(d, p, base, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/packet_loader.md
Name: packet_loader

Overview:
- Ingress stage that sits directly upstream of the executor.
- Accepts a received packet as a byte stream and packs it big-endian into 32-bit SRAM words starting at a fixed base word address.
- Optionally zeroes the IPv4 header checksum field while packing.
- Once the packet is fully in SRAM, raises start_o with start_addr_o for the executor, then holds off the next packet until exec_done_i.

Parameters:
- BASE_ADDR, 64, word address of the first packet word; driven unchanged on start_addr_o.
- MAX_WORDS, 512, SRAM words available to one packet; longer packets are truncated and flagged.
- CLEAR_CSUM, 1, when 1, packet bytes 24 and 25 are written as 8'h00 (word BASE_ADDR+6, bits [31:16]).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_valid_i  in  1  byte valid
- rx_data_i  in  8  packet byte
- rx_last_i  in  1  marks the final byte of the packet
- rx_ready_o  out  1  loader can accept a byte this cycle
- sram_ce_o  out  1  SRAM chip enable; high only during loader writes
- sram_we_o  out  1  SRAM write enable
- sram_addr_o  out  `ADDR_BUS  SRAM word address
- sram_sel_o  out  4  byte lanes; bit3 = [31:24]
- sram_data_o  out  `DATA_BUS  write data
- start_o  out  1  executor start, level
- start_addr_o  out  `ADDR_BUS  executor start address (= BASE_ADDR)
- exec_done_i  in  1  executor finished
- pkt_len_o  out  16  byte count of the last accepted packet
- trunc_err_o  out  1  sticky: last packet exceeded MAX_WORDS*4 bytes

Behaviour:
- Reset values: every output is 0, except start_addr_o, which is the constant BASE_ADDR. State goes to RECV, counters clear. Reset in any state aborts the packet; partially written SRAM contents are left as-is.
- States:
  - RECV: rx_ready_o=1.
  - FLUSH: one cycle, lets the final write commit.
  - EXEC: start_o=1.
  - DRAIN: truncated packet; rx_ready_o=1 and bytes are discarded until rx_last_i.
- Byte handshake: a byte is accepted on a rising edge where rx_valid_i and rx_ready_o are both 1. byte_cnt increments per accepted byte.
- Packing: lane = byte_cnt[1:0]. Lane 0 goes to [31:24], lane 3 to [7:0]. The word buffer clears at the start of every word.
- Checksum clear: when CLEAR_CSUM=1 and byte_cnt is 24 or 25, the byte is stored as 8'h00.
- Write issue:
  - On the edge that accepts lane 3 or an rx_last_i byte, the loader registers sram_ce_o=1, sram_we_o=1, sram_addr_o=BASE_ADDR+word_idx and sram_data_o = the full word.
  - sram_sel_o is 4'b1111 for a full word. For a partial last word it is the lanes written so far: 1000, 1100, 1110.
  - The write pulse lasts exactly one cycle. ce and we drop the next cycle unless another word completes.
  - The loader sustains 1 byte/cycle with at most one write per 4 cycles.
- Last byte: RECV -> FLUSH. pkt_len_o <= byte_cnt+1 and trunc_err_o <= 0. Then FLUSH -> EXEC.
- EXEC: start_o held at 1 and rx_ready_o=0. When exec_done_i=1 is sampled, start_o <= 0 and the state returns to RECV. The next packet can be accepted one cycle later.
- exec_done_i is ignored outside EXEC.
- Overflow: if a byte arrives when word_idx==MAX_WORDS, no write is issued and the loader enters DRAIN. It discards bytes until rx_last_i, then returns to RECV with trunc_err_o=1 and pkt_len_o=MAX_WORDS*4. start_o is never raised for that packet.
- Packet of exactly MAX_WORDS*4 bytes: last byte fills the final word, so the packet is legal with no error.
- rx_last_i together with a lane-3 byte: a single full-word write, no extra empty word.
- One-byte packet: a single write with sel=1000 at BASE_ADDR.
- Writes run sequentially in word order with addresses BASE_ADDR .. BASE_ADDR+ceil(len/4)-1. Addresses do not wrap.

Test Plan:
- Full packet: 40-byte packet of bytes 0x00..0x27, CLEAR_CSUM=1, no stalls. Required: 10 writes at addr 64..73, each sel=1111. Word 64=0x00010203. Word 70 bytes 24 and 25 are zeroed. start_o rises 2 cycles after the last byte, pkt_len_o=40, trunc_err_o=0.
- Partial last word: 42-byte packet. Required: final write to addr 74 with sel=1100, data=0x28290000. With CLEAR_CSUM=0, word 70 = 0x18191A1B.
- Backpressure: a second packet is presented while start_o=1. Required: rx_ready_o=0 and no SRAM activity. After exec_done_i pulses, start_o=0 and rx_ready_o=1 on the next cycle; the second packet then loads at addr 64.
- Truncation: MAX_WORDS=4, 20-byte packet. Required: writes only to addr 64..67, no write for bytes 16..19, trunc_err_o=1, pkt_len_o=16, start_o stays 0. A following 8-byte packet loads normally and clears trunc_err_o.
- Boundaries and gaps: 1-byte packet 0xAB -> one write, sel=1000, data=0xAB000000. A 16-byte packet with MAX_WORDS=4 -> accepted with no error. rx_valid_i gaps inside a word -> identical SRAM image to the gap-free case.
- Reset mid-packet: assert rst after byte 6. Required: all outputs are 0 the next cycle and start_o stays 0. A new 8-byte packet then writes addr 64..65.
